// File: rtl/psr_window_trap_controller_pkg.sv
// Shared definitions for the PSR window/trap controller: op codes, FSM states,
// trap type codes and PSR field positions.
package psr_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_SAVE    = 3'd1,
    OP_RESTORE = 3'd2,
    OP_TRAP    = 3'd3,
    OP_RETT    = 3'd4,
    OP_WRPSR   = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_COMMIT,
    ST_FAULT,
    ST_ERROR
  } state_e;

  localparam logic [7:0] TT_ILLEGAL_INSTR  = 8'h02;
  localparam logic [7:0] TT_PRIV_INSTR     = 8'h03;
  localparam logic [7:0] TT_WIN_OVERFLOW   = 8'h05;
  localparam logic [7:0] TT_WIN_UNDERFLOW  = 8'h06;

  localparam int PSR_S_BIT  = 7;
  localparam int PSR_PS_BIT = 6;
  localparam int PSR_ET_BIT = 5;
  localparam logic [31:0] PSR_RESERVED_MASK = 32'h000F_C000;

  // Trap entry: enter supervisor, remember previous S, disable traps, rotate window.
  function automatic logic [31:0] trap_entry_word(input logic [31:0] psr,
                                                  input logic [4:0]  new_cwp);
    logic [31:0] w;
    w = psr & ~PSR_RESERVED_MASK;
    w[PSR_PS_BIT] = psr[PSR_S_BIT];
    w[PSR_S_BIT]  = 1'b1;
    w[PSR_ET_BIT] = 1'b0;
    w[4:0]        = new_cwp;
    return w;
  endfunction

endpackage

// File: rtl/psr_window_trap_controller_if.sv
// Control-unit <-> PSR controller bundle; master is the control unit side.
interface psr_window_trap_controller_if;
  logic        op_valid;
  logic [2:0]  op;
  logic        op_ready;
  logic [7:0]  trap_type;
  logic [31:0] wr_data;
  logic [31:0] psr_in;
  logic [31:0] wim;
  logic        psr_ld;
  logic [31:0] psr_data;
  logic        tt_ld;
  logic [7:0]  tt_out;
  logic        done;
  logic        error_mode;

  modport master (
    output op_valid, op, trap_type, wr_data, psr_in, wim,
    input  op_ready, psr_ld, psr_data, tt_ld, tt_out, done, error_mode
  );

  modport slave (
    input  op_valid, op, trap_type, wr_data, psr_in, wim,
    output op_ready, psr_ld, psr_data, tt_ld, tt_out, done, error_mode
  );
endinterface

// File: rtl/psr_window_trap_controller_cwp_mod_unit.sv
// Combinational window pointer neighbours (CWP-1, CWP+1 modulo NWINDOWS) and
// the invalid-mask bits of those neighbour windows.
module cwp_mod_unit #(
  parameter int NWINDOWS = 8
) (
  input  logic [4:0]  cwp,
  input  logic [31:0] wim,
  output logic [4:0]  cwp_dec,
  output logic [4:0]  cwp_inc,
  output logic        wim_dec,
  output logic        wim_inc
);

  localparam logic [4:0] CWP_MAX = 5'(NWINDOWS - 1);

  always_comb begin
    cwp_dec = (cwp == 5'd0) ? CWP_MAX : cwp - 5'd1;
    cwp_inc = (cwp >= CWP_MAX) ? 5'd0 : cwp + 5'd1;
    wim_dec = wim[cwp_dec];
    wim_inc = wim[cwp_inc];
  end

endmodule

// File: rtl/psr_window_trap_controller.sv
// Sequencer for whole-PSR updates (SAVE/RESTORE/TRAP/RETT/WRPSR).
// Define PSR_WIM_CHECK_EN to enable window-invalid faults (0x05/0x06).
module psr_window_trap_controller
  import psr_ctrl_pkg::*;
#(
  parameter int NWINDOWS = 8
) (
  input logic clk,
  input logic rst,
  psr_window_trap_controller_if.slave bus
);

`ifdef PSR_WIM_CHECK_EN
  localparam bit WIM_CHECK = 1'b1;
`else
  localparam bit WIM_CHECK = 1'b0;
`endif

  localparam logic [5:0] NWIN = 6'(NWINDOWS);

  logic [4:0] cwp_dec, cwp_inc;
  logic       wim_dec, wim_inc;

  cwp_mod_unit #(.NWINDOWS(NWINDOWS)) u_cwp (
    .cwp     (bus.psr_in[4:0]),
    .wim     (bus.wim),
    .cwp_dec (cwp_dec),
    .cwp_inc (cwp_inc),
    .wim_dec (wim_dec),
    .wim_inc (wim_inc)
  );

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [7:0]  trap_type_q, trap_type_d;
  logic [23:0] wr_data_q, wr_data_d;
  logic [31:0] fault_word_q, fault_word_d;
  logic [7:0]  fault_code_q, fault_code_d;
  logic        fault_et_q, fault_et_d;
  logic        psr_ld_q, psr_ld_d;
  logic [31:0] psr_data_q, psr_data_d;
  logic        tt_ld_q, tt_ld_d;
  logic [7:0]  tt_out_q, tt_out_d;
  logic        done_q, done_d;
  logic        op_ready_q, op_ready_d;
  logic        error_mode_q, error_mode_d;

  logic [31:0] next_word, trap_word;
  logic        fault;
  logic [7:0]  fault_code;
  logic        psr_s, psr_ps, psr_et;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    trap_type_d  = trap_type_q;
    wr_data_d    = wr_data_q;
    fault_word_d = fault_word_q;
    fault_code_d = fault_code_q;
    fault_et_d   = fault_et_q;
    psr_ld_d     = 1'b0;
    psr_data_d   = '0;
    tt_ld_d      = 1'b0;
    tt_out_d     = '0;
    done_d       = 1'b0;

    psr_s      = bus.psr_in[PSR_S_BIT];
    psr_ps     = bus.psr_in[PSR_PS_BIT];
    psr_et     = bus.psr_in[PSR_ET_BIT];
    trap_word  = trap_entry_word(bus.psr_in, cwp_dec);
    next_word  = bus.psr_in & ~PSR_RESERVED_MASK;
    fault      = 1'b0;
    fault_code = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.op_valid && op_ready_q) begin
          trap_type_d = bus.trap_type;
          wr_data_d   = bus.wr_data[23:0];
          case (bus.op)
            OP_SAVE, OP_RESTORE, OP_TRAP, OP_RETT, OP_WRPSR: begin
              op_d    = op_e'(bus.op);
              state_d = ST_EVAL;
            end
            default: done_d = 1'b1;
          endcase
        end
      end

      ST_EVAL: begin
        case (op_q)
          OP_SAVE: begin
            next_word[4:0] = cwp_dec;
            if (WIM_CHECK && wim_dec) begin
              fault      = 1'b1;
              fault_code = TT_WIN_OVERFLOW;
            end
          end
          OP_RESTORE: begin
            next_word[4:0] = cwp_inc;
            if (WIM_CHECK && wim_inc) begin
              fault      = 1'b1;
              fault_code = TT_WIN_UNDERFLOW;
            end
          end
          OP_TRAP: next_word = trap_word;
          OP_RETT: begin
            if (psr_et) begin
              fault      = 1'b1;
              fault_code = TT_ILLEGAL_INSTR;
            end else if (!psr_s) begin
              fault      = 1'b1;
              fault_code = TT_PRIV_INSTR;
            end else begin
              next_word[PSR_ET_BIT] = 1'b1;
              next_word[PSR_S_BIT]  = psr_ps;
              next_word[4:0]        = cwp_inc;
              if (WIM_CHECK && wim_inc) begin
                fault      = 1'b1;
                fault_code = TT_WIN_UNDERFLOW;
              end
            end
          end
          OP_WRPSR: begin
            if (!psr_s) begin
              fault      = 1'b1;
              fault_code = TT_PRIV_INSTR;
            end else if ({1'b0, wr_data_q[4:0]} >= NWIN) begin
              fault      = 1'b1;
              fault_code = TT_ILLEGAL_INSTR;
            end else begin
              next_word = {bus.psr_in[31:24], wr_data_q} & ~PSR_RESERVED_MASK;
            end
          end
          default: ;
        endcase

        // A trap taken while traps are disabled has nowhere to go.
        if (op_q == OP_TRAP && !psr_et) begin
          state_d = ST_ERROR;
        end else if (fault) begin
          state_d      = ST_FAULT;
          fault_word_d = trap_word;
          fault_code_d = fault_code;
          fault_et_d   = psr_et;
        end else begin
          state_d    = ST_COMMIT;
          psr_ld_d   = 1'b1;
          psr_data_d = next_word;
          done_d     = 1'b1;
          if (op_q == OP_TRAP) begin
            tt_ld_d  = 1'b1;
            tt_out_d = trap_type_q;
          end
        end
      end

      ST_FAULT: begin
        if (fault_et_q) begin
          state_d    = ST_COMMIT;
          psr_ld_d   = 1'b1;
          psr_data_d = fault_word_q;
          tt_ld_d    = 1'b1;
          tt_out_d   = fault_code_q;
          done_d     = 1'b1;
        end else begin
          state_d = ST_ERROR;
        end
      end

      ST_COMMIT: state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_IDLE;
    endcase

    op_ready_d   = (state_d == ST_IDLE);
    error_mode_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_NOP;
      trap_type_q  <= '0;
      wr_data_q    <= '0;
      fault_word_q <= '0;
      fault_code_q <= '0;
      fault_et_q   <= 1'b0;
      psr_ld_q     <= 1'b0;
      psr_data_q   <= '0;
      tt_ld_q      <= 1'b0;
      tt_out_q     <= '0;
      done_q       <= 1'b0;
      op_ready_q   <= 1'b1;
      error_mode_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      trap_type_q  <= trap_type_d;
      wr_data_q    <= wr_data_d;
      fault_word_q <= fault_word_d;
      fault_code_q <= fault_code_d;
      fault_et_q   <= fault_et_d;
      psr_ld_q     <= psr_ld_d;
      psr_data_q   <= psr_data_d;
      tt_ld_q      <= tt_ld_d;
      tt_out_q     <= tt_out_d;
      done_q       <= done_d;
      op_ready_q   <= op_ready_d;
      error_mode_q <= error_mode_d;
    end
  end

  assign bus.op_ready   = op_ready_q;
  assign bus.psr_ld     = psr_ld_q;
  assign bus.psr_data   = psr_data_q;
  assign bus.tt_ld      = tt_ld_q;
  assign bus.tt_out     = tt_out_q;
  assign bus.done       = done_q;
  assign bus.error_mode = error_mode_q;

endmodule

// File: tb/tb_psr_window_trap_controller.sv
// Self-checking bench for psr_window_trap_controller: directed vectors, a
// spec-level model checked every cycle, and hand-computed literal results.
module tb_psr_window_trap_controller;

  localparam int N = 8;
`ifdef PSR_WIM_CHECK_EN
  localparam bit WIM_ON = 1'b1;
`else
  localparam bit WIM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psr_window_trap_controller_if bus ();

  psr_window_trap_controller #(.NWINDOWS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          is_nop;
    bit          is_error;
    int          lat;
    bit          ld;
    logic [31:0] word;
    bit          tt_ld;
    logic [7:0]  tt;
  } exp_t;

  typedef struct {
    int          op;
    logic [31:0] psr;
    logic [31:0] wim;
    logic [7:0]  tt;
    logic [31:0] wr;
    bit          poke;
    bit          ld;
    logic [31:0] word;
    bit          ttld;
    logic [7:0]  ttv;
    int          lat;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  bit   check_en = 1'b0;
  bit   active = 1'b0;
  exp_t res;

  bit          cap_ld;
  logic [31:0] cap_word;
  bit          cap_ttld;
  logic [7:0]  cap_tt;
  int          cap_done_o;

  vec_t vecs[11];

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] trapWord(input logic [31:0] p, input int c);
    return {p[31:20], 6'b0, p[13:8], 1'b1, p[7], 1'b0, 5'(c)};
  endfunction

  // Expected outcome of one operation, from the field-level rules of the PSR.
  function automatic exp_t model(input int op, input logic [31:0] p, input logic [31:0] w,
                                 input logic [7:0] t, input logic [31:0] d);
    exp_t r;
    int cwp = int'(p[4:0]);
    int dec = (cwp + N - 1) % N;
    int inc = (cwp + 1) % N;
    bit s = p[7], ps = p[6], et = p[5];
    int fc = -1;
    r = '{default: 0};
    r.lat = 2;
    case (op)
      1: begin
        r.ld = 1; r.word = {p[31:20], 6'b0, p[13:5], 5'(dec)};
        if (WIM_ON && w[dec]) fc = 5;
      end
      2: begin
        r.ld = 1; r.word = {p[31:20], 6'b0, p[13:5], 5'(inc)};
        if (WIM_ON && w[inc]) fc = 6;
      end
      3: begin
        if (!et) r.is_error = 1;
        else begin r.ld = 1; r.word = trapWord(p, dec); r.tt_ld = 1; r.tt = t; end
      end
      4: begin
        if (et) fc = 2;
        else if (!s) fc = 3;
        else begin
          r.ld = 1; r.word = {p[31:20], 6'b0, p[13:8], ps, ps, 1'b1, 5'(inc)};
          if (WIM_ON && w[inc]) fc = 6;
        end
      end
      5: begin
        if (!s) fc = 3;
        else if (int'(d[4:0]) >= N) fc = 2;
        else begin r.ld = 1; r.word = {p[31:24], d[23:20], 6'b0, d[13:0]}; end
      end
      default: begin r.is_nop = 1; r.lat = 1; end
    endcase
    if (fc >= 0) begin
      r.lat = 3;
      if (et) begin r.ld = 1; r.word = trapWord(p, dec); r.tt_ld = 1; r.tt = 8'(fc); end
      else begin r.is_error = 1; r.ld = 0; r.tt_ld = 0; end
    end
    return r;
  endfunction

  // Every cycle: DUT outputs against the model's timeline for the current op.
  always @(negedge clk) begin : compare
    int o;
    bit hit, e_ld, e_done, e_ttld, e_rdy, e_err;
    if (check_en) begin
      o = cyc - accept_cyc + 1;
      e_ld = 0; e_done = 0; e_ttld = 0; e_rdy = 1; e_err = 0;
      if (active) begin
        if (res.is_error) begin
          e_rdy = 0;
          e_err = (o >= res.lat);
        end else begin
          hit    = (o == res.lat);
          e_ld   = hit && res.ld;
          e_done = hit;
          e_ttld = hit && res.tt_ld;
          e_rdy  = res.is_nop || (o > res.lat);
        end
        if (bus.psr_ld) begin cap_ld = 1; cap_word = bus.psr_data; end
        if (bus.tt_ld)  begin cap_ttld = 1; cap_tt = bus.tt_out; end
        if (bus.done)   cap_done_o = o;
      end
      checkOutput("psr_ld", 32'(bus.psr_ld), 32'(e_ld));
      checkOutput("done", 32'(bus.done), 32'(e_done));
      checkOutput("tt_ld", 32'(bus.tt_ld), 32'(e_ttld));
      checkOutput("op_ready", 32'(bus.op_ready), 32'(e_rdy));
      checkOutput("error_mode", 32'(bus.error_mode), 32'(e_err));
      if (e_ld)   checkOutput("psr_data", bus.psr_data, res.word);
      if (e_ttld) checkOutput("tt_out", 32'(bus.tt_out), 32'(res.tt));
    end
  end

  task automatic applyStimulus(input vec_t v);
    exp_t r;
    int waitc;
    r = model(v.op, v.psr, v.wim, v.tt, v.wr);
    @(negedge clk);
    waitc = 0;
    while (!bus.op_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    checkOutput("ready_before_accept", 32'(bus.op_ready), 32'd1);
    bus.op        = 3'(v.op);
    bus.psr_in    = v.psr;
    bus.wim       = v.wim;
    bus.trap_type = v.tt;
    bus.wr_data   = v.wr;
    bus.op_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    res = r;
    accept_cyc = cyc;
    active = 1'b1;
    cap_ld = 0; cap_word = '0; cap_ttld = 0; cap_tt = '0; cap_done_o = -1;
    for (int k = 1; k <= r.lat + 2; k++) begin
      @(negedge clk);
      if (v.poke && k == 1) begin bus.op_valid = 1'b1; bus.op = 3'd2; end
      if (v.poke && k == 2) bus.op_valid = 1'b0;
    end
    #1;
    checkOutput("lit_psr_ld_seen", 32'(cap_ld), 32'(v.ld));
    if (v.ld) checkOutput("lit_psr_data", cap_word, v.word);
    checkOutput("lit_tt_ld_seen", 32'(cap_ttld), 32'(v.ttld));
    if (v.ttld) checkOutput("lit_tt_out", 32'(cap_tt), 32'(v.ttv));
    checkOutput("lit_done_cycle", 32'(cap_done_o), 32'(v.lat));
  endtask

  task automatic doReset();
    check_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    active = 1'b0;
    #1;
    checkOutput("rst_op_ready", 32'(bus.op_ready), 32'd1);
    checkOutput("rst_psr_ld", 32'(bus.psr_ld), 32'd0);
    checkOutput("rst_psr_data", bus.psr_data, 32'd0);
    checkOutput("rst_tt_ld", 32'(bus.tt_ld), 32'd0);
    checkOutput("rst_tt_out", 32'(bus.tt_out), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_error_mode", 32'(bus.error_mode), 32'd0);
    check_en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.op_valid = 1'b0; bus.op = '0; bus.trap_type = '0;
    bus.wr_data = '0; bus.psr_in = '0; bus.wim = '0;

    //          op  psr           wim           tt     wr            poke ld word          ttld tt     lat
    vecs[0]  = '{7, 32'h0000_0080, 32'h0,        8'h00, 32'h0,        0, 0, 32'h0,         0, 8'h00, 1};
    vecs[1]  = '{1, 32'h0000_0080, 32'h0,        8'h00, 32'h0,        0, 1, 32'h0000_0087, 0, 8'h00, 2};
`ifdef PSR_WIM_CHECK_EN
    vecs[2]  = '{2, 32'h0000_00A7, 32'h1,        8'h00, 32'h0,        0, 1, 32'h0000_00C6, 1, 8'h06, 3};
    vecs[8]  = '{1, 32'h0000_00A5, 32'h10,       8'h00, 32'h0,        0, 1, 32'h0000_00C4, 1, 8'h05, 3};
`else
    vecs[2]  = '{2, 32'h0000_00A7, 32'h1,        8'h00, 32'h0,        0, 1, 32'h0000_00A0, 0, 8'h00, 2};
    vecs[8]  = '{1, 32'h0000_00A5, 32'h10,       8'h00, 32'h0,        0, 1, 32'h0000_00A4, 0, 8'h00, 2};
`endif
    vecs[3]  = '{5, 32'h0000_0020, 32'h0,        8'h00, 32'h0000_00A3, 0, 1, 32'h0000_0087, 1, 8'h03, 3};
    vecs[4]  = '{5, 32'h0000_00A2, 32'h0,        8'h00, 32'h0000_0009, 0, 1, 32'h0000_00C1, 1, 8'h02, 3};
    vecs[5]  = '{4, 32'h0000_0083, 32'h0,        8'h00, 32'h0,        0, 1, 32'h0000_0024, 0, 8'h00, 2};
    vecs[6]  = '{5, 32'hF300_0080, 32'hFF,       8'h00, 32'h12FF_FFE5, 1, 1, 32'hF3F0_3FE5, 0, 8'h00, 2};
    vecs[7]  = '{3, 32'h0000_01E0, 32'hFFFF_FFFF, 8'h11, 32'h0,        0, 1, 32'h0000_01C7, 1, 8'h11, 2};
    vecs[9]  = '{4, 32'h0000_00E4, 32'h0,        8'h00, 32'h0,        0, 1, 32'h0000_00C3, 1, 8'h02, 3};
    vecs[10] = '{4, 32'h0000_00C7, 32'h2,        8'h00, 32'h0,        0, 1, 32'h0000_00E0, 0, 8'h00, 2};

    doReset();
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset during EVAL: the pending SAVE must never load the PSR.
    @(negedge clk);
    bus.op = 3'd1; bus.psr_in = 32'h0000_0080; bus.wim = '0; bus.op_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    check_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    active = 1'b0;
    #1;
    checkOutput("midrst_psr_ld", 32'(bus.psr_ld), 32'd0);
    checkOutput("midrst_op_ready", 32'(bus.op_ready), 32'd1);
    checkOutput("midrst_done", 32'(bus.done), 32'd0);
    check_en = 1'b1;
    repeat (3) @(negedge clk);

    // Trap with ET=0 locks the controller into error mode until reset.
    @(negedge clk);
    res = model(3, 32'h0000_0080, 32'h0, 8'h80, 32'h0);
    bus.op = 3'd3; bus.psr_in = 32'h0000_0080; bus.trap_type = 8'h80; bus.op_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    accept_cyc = cyc;
    active = 1'b1;
    repeat (4) @(negedge clk);
    bus.op = 3'd1; bus.op_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.op_valid = 1'b0;
    #1;
    checkOutput("err_error_mode", 32'(bus.error_mode), 32'd1);
    checkOutput("err_op_ready", 32'(bus.op_ready), 32'd0);
    doReset();
    applyStimulus(vecs[1]);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
